// File: rtl/gb_row_port_sched_pkg.sv
// Shared types and defaults for the board-memory row-port scheduler.
package gb_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } port_state_e;

  localparam int          NUM_ROWS_DEF  = 20;
  localparam logic [31:0] FULL_MASK_DEF = 32'h0000_03FF;

  typedef logic [4:0] row_idx_t;

  // Number of set bits in a 32-bit word.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gb_row_port_sched_arb.sv
// Two-requester round-robin arbiter: req[0]=CPU, req[1]=GFX.
// On contention the requester not granted last wins; last-grant resets to GFX.
module gb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_gfx;

  // Grant decode: single requester always wins, tie goes to the other side.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_gfx ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Remember who won whenever a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gfx <= 1'b1;
    end else if (adv && (gnt != 2'b00)) begin
      last_gfx <= gnt[1];
    end
  end

endmodule

// File: rtl/gb_row_port_sched.sv
// Row-read port scheduler: shares the board memory row port between CPU
// reads and the per-frame graphics scan, and builds the full-row mask.
module gb_row_port_sched
  import gb_ctrl_pkg::*;
#(
  parameter int          NUM_ROWS  = NUM_ROWS_DEF,
  parameter logic [31:0] FULL_MASK = FULL_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [4:0]  cpu_row,
  output logic        cpu_gnt,
  output logic        cpu_rdata_vld,
  output logic [31:0] cpu_rdata,
  input  logic        frame_req,
  output logic        gfx_row_vld,
  output logic [4:0]  gfx_row_idx,
  output logic [31:0] gfx_row_data,
  input  logic        gfx_ready,
  output logic        frame_done,
  output logic        frame_overrun,
  output logic [31:0] full_row_mask,
  output logic [5:0]  full_row_cnt,
  output logic [4:0]  mem_line_num,
  input  logic [31:0] mem_row_data
);

  port_state_e state;
  logic        own_cpu;
  logic        cpu_oob;
  logic [5:0]  scan_row;
  logic        frame_active;
  logic        frame_pend;
  logic [31:0] acc_mask;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        arb_adv;
  logic        gfx_accept;
  logic        frame_end;
  logic        gfx_free;
  logic        gfx_cap;

  assign gfx_accept = gfx_row_vld & gfx_ready;
  assign frame_end  = gfx_accept & frame_active & (gfx_row_idx == 5'(NUM_ROWS - 1));
  // The port is single-issue, so an output register that is empty (or being
  // drained this cycle) at grant time is guaranteed empty at capture time.
  assign gfx_free   = ~gfx_row_vld | gfx_ready;
  assign req[0]     = cpu_req;
  assign req[1]     = frame_active & (scan_row < 6'(NUM_ROWS)) & gfx_free;
  assign arb_adv    = (state == S_IDLE);
  assign cpu_gnt    = (state == S_IDLE) & gnt[0];
  assign gfx_cap    = (state == S_CAPTURE) & ~own_cpu;

  gb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .adv   (arb_adv),
    .gnt   (gnt)
  );

  // Port FSM: arbitrate, drive the row index, wait one cycle, capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      own_cpu      <= 1'b0;
      cpu_oob      <= 1'b0;
      mem_line_num <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt != 2'b00) begin
            own_cpu      <= gnt[0];
            cpu_oob      <= ({1'b0, cpu_row} >= 6'(NUM_ROWS));
            mem_line_num <= gnt[0] ? cpu_row : scan_row[4:0];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE:   state <= S_CAPTURE;
        S_CAPTURE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // CPU return register: out-of-range rows read back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_vld <= 1'b0;
      cpu_rdata     <= '0;
    end else begin
      cpu_rdata_vld <= 1'b0;
      if ((state == S_CAPTURE) && own_cpu) begin
        cpu_rdata_vld <= 1'b1;
        cpu_rdata     <= cpu_oob ? '0 : mem_row_data;
      end
    end
  end

  // Graphics output register, scan counter, mask accumulator and frame control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gfx_row_vld   <= 1'b0;
      gfx_row_idx   <= '0;
      gfx_row_data  <= '0;
      scan_row      <= '0;
      acc_mask      <= '0;
      frame_active  <= 1'b0;
      frame_pend    <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      full_row_mask <= '0;
      full_row_cnt  <= '0;
    end else begin
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      if (gfx_accept) begin
        gfx_row_vld <= 1'b0;
      end
      if (gfx_cap) begin
        gfx_row_vld  <= 1'b1;
        gfx_row_data <= mem_row_data;
        gfx_row_idx  <= scan_row[4:0];
        scan_row     <= scan_row + 6'd1;
        if ((mem_row_data & FULL_MASK) == FULL_MASK) begin
          acc_mask[scan_row[4:0]] <= 1'b1;
        end
      end
      // A request coinciding with frame end is folded into the pending slot
      // before the restart decision, so it starts the next frame directly.
      if (frame_end) begin
        full_row_mask <= acc_mask;
        full_row_cnt  <= popcount32(acc_mask);
        frame_done    <= 1'b1;
        frame_overrun <= frame_pend & frame_req;
        frame_active  <= frame_pend | frame_req;
        frame_pend    <= 1'b0;
        scan_row      <= '0;
        acc_mask      <= '0;
      end else if (frame_req) begin
        if (!frame_active) begin
          frame_active <= 1'b1;
          scan_row     <= '0;
          acc_mask     <= '0;
        end else if (frame_pend) begin
          frame_overrun <= 1'b1;
        end else begin
          frame_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_row_port_sched.sv
// Directed bench for gb_row_port_sched with a memory model and scoreboards
// for CPU reads, graphics rows and per-frame masks.
module tb_gb_row_port_sched;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] d;
  } cpu_exp_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } gfx_exp_t;

  typedef struct packed {
    logic [31:0] m;
    logic [5:0]  c;
  } mask_exp_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [4:0]  cpu_row;
  logic        cpu_gnt;
  logic        cpu_rdata_vld;
  logic [31:0] cpu_rdata;
  logic        frame_req;
  logic        gfx_row_vld;
  logic [4:0]  gfx_row_idx;
  logic [31:0] gfx_row_data;
  logic        gfx_ready;
  logic        frame_done;
  logic        frame_overrun;
  logic [31:0] full_row_mask;
  logic [5:0]  full_row_cnt;
  logic [4:0]  mem_line_num;
  logic [31:0] mem_row_data;

  logic [31:0] mem [32];
  logic        ready_base;
  logic        hold7;
  logic [31:0] cyc;

  int checks;
  int failures;
  int done_cnt;
  int ovr_cnt;

  cpu_exp_t  cpu_q[$];
  gfx_exp_t  gfx_q[$];
  mask_exp_t mask_q[$];

  logic        prev_stall;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;

  gb_row_port_sched #(
    .NUM_ROWS  (20),
    .FULL_MASK (32'h0000_03FF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req       (cpu_req),
    .cpu_row       (cpu_row),
    .cpu_gnt       (cpu_gnt),
    .cpu_rdata_vld (cpu_rdata_vld),
    .cpu_rdata     (cpu_rdata),
    .frame_req     (frame_req),
    .gfx_row_vld   (gfx_row_vld),
    .gfx_row_idx   (gfx_row_idx),
    .gfx_row_data  (gfx_row_data),
    .gfx_ready     (gfx_ready),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .full_row_mask (full_row_mask),
    .full_row_cnt  (full_row_cnt),
    .mem_line_num  (mem_line_num),
    .mem_row_data  (mem_row_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Board memory: data follows the driven row index by one cycle.
  always @(posedge clk) mem_row_data <= mem[mem_line_num];

  // Graphics stalls on row 7 while hold7 is set.
  assign gfx_ready = ready_base & ~(hold7 & gfx_row_vld & (gfx_row_idx == 5'd7));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cpu_exp_t  ce;
    gfx_exp_t  ge;
    mask_exp_t me;
    if (rst_n) begin
      if (cpu_gnt) begin
        check("cpu_gnt_needs_req", 32'(cpu_req), 32'd1);
        cpu_q.push_back('{t: cyc + 32'd3, d: (cpu_row < 5'd20) ? mem[cpu_row] : 32'd0});
      end
      if (cpu_rdata_vld) begin
        if (cpu_q.size() == 0) begin
          check("cpu_vld_unexpected", 32'(cpu_rdata_vld), 32'd0);
        end else begin
          ce = cpu_q.pop_front();
          check("cpu_latency", cyc, ce.t);
          check("cpu_rdata", cpu_rdata, ce.d);
        end
      end
      if (prev_stall) begin
        check("gfx_stall_vld", 32'(gfx_row_vld), 32'd1);
        check("gfx_stall_idx", 32'(gfx_row_idx), 32'(prev_idx));
        check("gfx_stall_data", gfx_row_data, prev_data);
      end
      if (gfx_row_vld && gfx_ready) begin
        if (gfx_q.size() == 0) begin
          check("gfx_row_unexpected", 32'(gfx_row_idx), 32'hFFFF_FFFF);
        end else begin
          ge = gfx_q.pop_front();
          check("gfx_row_idx", 32'(gfx_row_idx), 32'(ge.idx));
          check("gfx_row_data", gfx_row_data, ge.data);
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (mask_q.size() == 0) begin
          check("frame_done_unexpected", 32'(frame_done), 32'd0);
        end else begin
          me = mask_q.pop_front();
          check("full_row_mask", full_row_mask, me.m);
          check("full_row_cnt", 32'(full_row_cnt), 32'(me.c));
        end
      end
      if (frame_overrun) ovr_cnt++;
      prev_stall = gfx_row_vld & ~gfx_ready;
      prev_idx   = gfx_row_idx;
      prev_data  = gfx_row_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [4:0] row);
    int n;
    n = 0;
    @(posedge clk); #1;
    cpu_row = row;
    cpu_req = 1'b1;
    @(negedge clk);
    while (!cpu_gnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cpu_gnt_wait", 32'(cpu_gnt), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic drain_cpu();
    int n;
    n = 0;
    while (cpu_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_frame();
    logic [31:0] m;
    logic [5:0]  c;
    m = '0;
    c = '0;
    for (int r = 0; r < 20; r++) begin
      gfx_q.push_back('{idx: 5'(r), data: mem[r]});
      if ((mem[r] & 32'h0000_03FF) == 32'h0000_03FF) begin
        m[r] = 1'b1;
        c    = c + 6'd1;
      end
    end
    mask_q.push_back('{m: m, c: c});
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_count", 32'(done_cnt), 32'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] gt [4];
    int          g_n;
    int          n;
    logic [31:0] s0;

    checks     = 0;
    failures   = 0;
    done_cnt   = 0;
    ovr_cnt    = 0;
    prev_stall = 1'b0;
    rst_n      = 1'b0;
    cpu_req    = 1'b0;
    cpu_row    = '0;
    frame_req  = 1'b0;
    ready_base = 1'b1;
    hold7      = 1'b0;
    for (int r = 0; r < 32; r++) begin
      mem[r] = (r < 20) ? 32'h0000_0155 : (32'hA5A5_0000 | 32'(r));
    end
    mem[3]  = 32'h0000_03FF;
    mem[19] = 32'h0000_03FF;
    mem[5]  = 32'h0000_03FF;
    for (int i = 0; i < 4; i++) gt[i] = '0;

    // Reset state
    #12;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_cpu_rdata_vld", 32'(cpu_rdata_vld), 32'd0);
    check("rst_gfx_row_vld", 32'(gfx_row_vld), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_full_row_mask", full_row_mask, 32'd0);
    check("rst_mem_line_num", 32'(mem_line_num), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // CPU only, in range and out of range
    cpu_read(5'd5);
    drain_cpu();
    check("cpu_row5_rdata", cpu_rdata, 32'h0000_03FF);
    cpu_read(5'd25);
    drain_cpu();
    mem[5] = 32'h0000_0155;

    // Full frame with graphics always ready
    push_frame();
    pulse_frame();
    wait_done(1);
    check("frame1_mask", full_row_mask, 32'h0008_0008);
    check("frame1_cnt", 32'(full_row_cnt), 32'd2);

    // Contention: CPU held high during a frame
    push_frame();
    pulse_frame();
    cpu_row = 5'd10;
    cpu_req = 1'b1;
    g_n = 0;
    n   = 0;
    while (g_n < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (cpu_gnt) begin
        gt[g_n] = cyc;
        g_n++;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("contention_grants", 32'(g_n), 32'd4);
    for (int i = 1; i < 4; i++) begin
      check("cpu_gfx_alternate", gt[i] - gt[i-1], 32'd6);
    end
    wait_done(2);
    drain_cpu();

    // Graphics stall on row 7 with CPU reads serviced meanwhile
    hold7 = 1'b1;
    push_frame();
    pulse_frame();
    n = 0;
    @(negedge clk);
    while (!(gfx_row_vld && !gfx_ready && gfx_row_idx == 5'd7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_row7_seen", 32'(gfx_row_idx), 32'd7);
    s0 = cyc;
    cpu_read(5'd2);
    cpu_read(5'd9);
    n = 0;
    while (cyc < s0 + 32'd12 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_cpu_serviced", 32'(cpu_q.size()), 32'd0);
    @(posedge clk); #1;
    hold7 = 1'b0;
    wait_done(3);

    // Three frame requests during one scan: one pending, one dropped
    push_frame();
    pulse_frame();
    tick(8);
    push_frame();
    pulse_frame();
    tick(8);
    pulse_frame();
    wait_done(5);
    check("frame_overrun_pulses", 32'(ovr_cnt), 32'd1);

    // Reset in the capture cycle of a CPU read
    cpu_read(5'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    cpu_q.delete();
    check("arst_cpu_rdata_vld", 32'(cpu_rdata_vld), 32'd0);
    check("arst_cpu_rdata", cpu_rdata, 32'd0);
    check("arst_gfx_row_vld", 32'(gfx_row_vld), 32'd0);
    check("arst_full_row_mask", full_row_mask, 32'd0);
    check("arst_full_row_cnt", 32'(full_row_cnt), 32'd0);
    check("arst_mem_line_num", 32'(mem_line_num), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("post_rst_no_vld", 32'(cpu_rdata_vld), 32'd0);
    cpu_read(5'd31);
    drain_cpu();
    check("cpu_row31_rdata", cpu_rdata, 32'd0);

    check("gfx_queue_empty", 32'(gfx_q.size()), 32'd0);
    check("mask_queue_empty", 32'(mask_q.size()), 32'd0);
    check("frame_done_total", 32'(done_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
